// File: rtl/stall_mem_responder.sv
// rtl/stall_mem_responder.sv - stalling memory responder with direct-mapped tag store
//
// Serves single-word read/write requests from a pipeline stage. A tag hit
// completes combinationally in the request cycle. A miss raises Stall for
// MISS_LAT cycles, then completes with Done. The completion installs the tag
// (write-allocate, write-through).
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   Addr          byte address, word index = Addr[MEM_AW:1]
//   Rd, Wr        level request strobes, held until Done
//   DataIn        write data, held with Wr
//   createdump    bench hook, no functional effect
//   DataOut       read data, valid with Done & Rd & ~err
//   Done          one-cycle completion strobe
//   Stall         busy; the initiator must hold its request stable
//   CacheHit      with Done: tag hit (1) or completed miss (0)
//   err           with Done: illegal request, nothing accessed
module stall_mem_responder #(
    parameter int MEM_AW   = 10,
    parameter int IDX_W    = 3,
    parameter int MISS_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic        Rd,
    input  logic        Wr,
    input  logic [15:0] DataIn,
    input  logic        createdump,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        CacheHit,
    output logic        err
);

    localparam int         TAG_W  = MEM_AW - IDX_W;
    localparam int         NWORDS = 1 << MEM_AW;
    localparam int         NLINES = 1 << IDX_W;
    localparam logic [3:0] LAT    = MISS_LAT[3:0];

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                  state_q;
    logic [3:0]              cnt_q;
    logic [MEM_AW-1:0]       addr_q;
    logic                    rd_q;
    logic                    wr_q;
    logic [15:0]             din_q;
    logic [NLINES-1:0]       valid_q;
    logic [TAG_W-1:0]        tag_q [NLINES];
    logic [15:0]             mem_q [NWORDS];

    // Upper address bits beyond the backing array and the dump hook are ignored.
    logic unused_inputs;
    assign unused_inputs = ^{createdump, Addr[15:MEM_AW+1]};

    // Live request decode
    logic [MEM_AW-1:0] word;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic              req;
    logic              bad;
    logic              hit;

    assign word = Addr[MEM_AW:1];
    assign idx  = word[IDX_W-1:0];
    assign tag  = word[MEM_AW-1:IDX_W];
    assign req  = Rd | Wr;
    assign bad  = (Rd & Wr) | (Addr[0] & req);
    assign hit  = valid_q[idx] & (tag_q[idx] == tag);

    // Latched request decode, used while the miss is in flight
    logic [IDX_W-1:0] lidx;
    logic [TAG_W-1:0] ltag;

    assign lidx = addr_q[IDX_W-1:0];
    assign ltag = addr_q[MEM_AW-1:IDX_W];

    // Array write port
    logic              mem_we;
    logic [MEM_AW-1:0] mem_wa;
    logic [15:0]       mem_wd;

    // Outputs are a function of state and, in IDLE, of the live request so
    // that hits and errors complete in the request cycle. Everything is forced
    // low while reset is held, and reset also blocks the array write.
    always_comb begin
        DataOut  = 16'h0000;
        Done     = 1'b0;
        Stall    = 1'b0;
        CacheHit = 1'b0;
        err      = 1'b0;
        mem_we   = 1'b0;
        mem_wa   = word;
        mem_wd   = DataIn;
        if (!rst) begin
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        if (bad) begin
                            Done = 1'b1;
                            err  = 1'b1;
                        end else if (hit) begin
                            Done     = 1'b1;
                            CacheHit = 1'b1;
                            // bad excludes Rd&Wr, so exactly one strobe is set here
                            if (Rd) begin
                                DataOut = mem_q[word];
                            end else begin
                                mem_we = 1'b1;
                            end
                        end else begin
                            Stall = 1'b1;
                        end
                    end
                end
                ST_BUSY: begin
                    Stall = 1'b1;
                end
                ST_DONE: begin
                    Done = 1'b1;
                    if (rd_q) begin
                        DataOut = mem_q[addr_q];
                    end
                    if (wr_q) begin
                        mem_we = 1'b1;
                        mem_wa = addr_q;
                        mem_wd = din_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Control FSM: miss sequencing, request latch and valid bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            din_q   <= 16'h0000;
            valid_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req && !bad && !hit) begin
                        addr_q <= word;
                        rd_q   <= Rd;
                        wr_q   <= Wr;
                        din_q  <= DataIn;
                        cnt_q  <= 4'd1;
                        // The request cycle itself is the first stall cycle,
                        // so a one-cycle latency skips BUSY entirely.
                        state_q <= (LAT == 4'd1) ? ST_DONE : ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q + 4'd1 == LAT) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    valid_q[lidx] <= 1'b1;
                    cnt_q         <= 4'd0;
                    state_q       <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Tag install on miss completion; tags are meaningless until valid is set
    always_ff @(posedge clk) begin
        if (!rst && state_q == ST_DONE) begin
            tag_q[lidx] <= ltag;
        end
    end

    // Backing word array, deliberately not reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

endmodule
